phase_sequencer: RTL and testbench

- Parametrised successor to the two-road light controller: sequences NUM_PHASES signal phases round-robin.
- Each phase runs green-base, an optional sensor-extended green, yellow, then all-red clearance.
- An optional pedestrian walk interval follows the clearance of a configured phase; empty side phases are optionally skipped.
- The interval timer is internal. It counts an external one-cycle tick enable from the existing divider and is loaded from programmable interval inputs.

---
 rtl/phase_seq_pkg.sv | 49 ++++
 rtl/interval_timer.sv | 36 +++
 rtl/phase_sequencer.sv | 172 +++++++++++++++++
 tb/tb_phase_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer.
//   state_e      : sequencer state with its fixed 3-bit debug encoding
//   lamp_decode  : per-phase lamp drive {red, yellow, green} for a state/phase pair
//   next_phase   : round-robin successor with optional skipping of phases without demand
package phase_seq_pkg;

  localparam int unsigned MaxPhases = 8;

  typedef enum logic [2:0] {
    StGreenBase = 3'd0,
    StGreenExt  = 3'd1,
    StYellow    = 3'd2,
    StAllRed    = 3'd3,
    StWalk      = 3'd4
  } state_e;

  // Returns {red, yellow, green} for phase q while phase p is active in state st.
  // Exactly one bit is ever set, so each head shows a single lamp.
  function automatic logic [2:0] lamp_decode(state_e st, logic [2:0] p, logic [2:0] q);
    logic [2:0] lamp;
    lamp = 3'b100;
    if (p == q) begin
      case (st)
        StGreenBase, StGreenExt: lamp = 3'b001;
        StYellow:                lamp = 3'b010;
        default:                 lamp = 3'b100;
      endcase
    end
    return lamp;
  endfunction

  // Successor of phase p among num phases. Phase 0 always terminates the search,
  // so the result is defined even with no demand anywhere.
  function automatic int unsigned next_phase(logic [2:0] p, logic [MaxPhases-1:0] demand,
                                             logic skip, int unsigned num);
    int unsigned q;
    logic        done;
    q    = int'(p);
    done = 1'b0;
    for (int unsigned i = 0; i < MaxPhases; i++) begin
      if (!done) begin
        q = (q + 1 >= num) ? 0 : q + 1;
        if (q == 0 || !skip || demand[q]) done = 1'b1;
      end
    end
    return q;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Interval down-counter for the phase sequencer.
//   clk_i      : system clock
//   load_i     : load cnt with max(load_val_i, 1); has priority over tick_i
//   load_val_i : interval length in ticks
//   tick_i     : timebase enable; cnt only moves on tick
//   expired_o  : tick arriving with cnt == 1 (the last tick of the interval)
module interval_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               tick_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      // A zero interval behaves as one tick.
      cnt_d = (load_val_i == '0) ? TIMER_W'(1) : load_val_i;
    end else if (tick_i && (cnt_q > TIMER_W'(1))) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  assign expired_o = tick_i && (cnt_q == TIMER_W'(1));

  // The owner asserts load_i during reset, so no separate reset is needed here.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_sequencer.sv
// Round-robin signal phase sequencer.
// Each phase runs green-base, optional sensor-extended green, yellow and all-red clearance;
// a latched pedestrian request is served as a WALK interval after clearance of WALK_PHASE.
// Ports:
//   clk, sys_reset (sync, active-high), tick (timebase enable)
//   prg_sync_in    : reprogram pulse, restarts at phase 0 keeping the walk request
//   sensor_sync_in : per-phase vehicle presence
//   walk_req       : pedestrian request pulse
//   base/ext/yel/clear/walk_time : interval lengths in ticks, sampled at state entry
//   red/yellow/green : registered per-phase lamp drives
//   walk, walk_ack   : walk lamp and one-cycle pulse on WALK entry
//   phase_idx, busy_state : current phase and state encoding
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 2,
  parameter int unsigned TIMER_W    = 8,
  parameter int unsigned WALK_PHASE = 0,
  parameter int unsigned SKIP_EMPTY = 1
) (
  input  logic                          clk,
  input  logic                          sys_reset,
  input  logic                          tick,
  input  logic                          prg_sync_in,
  input  logic [NUM_PHASES-1:0]         sensor_sync_in,
  input  logic                          walk_req,
  input  logic [TIMER_W-1:0]            base_time,
  input  logic [TIMER_W-1:0]            ext_time,
  input  logic [TIMER_W-1:0]            yel_time,
  input  logic [TIMER_W-1:0]            clear_time,
  input  logic [TIMER_W-1:0]            walk_time,
  output logic [NUM_PHASES-1:0]         red,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         green,
  output logic                          walk,
  output logic                          walk_ack,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic [2:0]                    busy_state
);

  localparam int unsigned PhW = $clog2(NUM_PHASES);

  state_e                state_q, state_d;
  logic [PhW-1:0]        phase_q, phase_d, next_p;
  logic [NUM_PHASES-1:0] demand_q, demand_d;
  logic                  walk_latch_q, walk_latch_d;
  logic [NUM_PHASES-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
  logic                  walk_q, walk_d, walk_ack_q;
  logic                  restart, expired, load, in_green, enter_walk, enter_green;
  logic [TIMER_W-1:0]    load_val;
  logic [2:0]            lamp;

  assign next_p = PhW'(next_phase(3'(phase_q), 8'(demand_q), SKIP_EMPTY != 0, NUM_PHASES));

  interval_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk_i     (clk),
    .load_i    (load),
    .load_val_i(load_val),
    .tick_i    (tick),
    .expired_o (expired)
  );

  // Next state, phase and timer load.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    restart = sys_reset | prg_sync_in;
    if (expired) begin
      case (state_q)
        StGreenBase: state_d = sensor_sync_in[phase_q] ? StGreenExt : StYellow;
        StGreenExt:  state_d = StYellow;
        StYellow:    state_d = StAllRed;
        StAllRed: begin
          if ((phase_q == PhW'(WALK_PHASE)) && walk_latch_q) begin
            state_d = StWalk;
          end else begin
            state_d = StGreenBase;
            phase_d = next_p;
          end
        end
        StWalk: begin
          state_d = StGreenBase;
          phase_d = next_p;
        end
        default: begin
          state_d = StGreenBase;
          phase_d = '0;
        end
      endcase
    end
    // Restart aborts mid-interval with no yellow run-out.
    if (restart) begin
      state_d = StGreenBase;
      phase_d = '0;
    end

    load = restart | expired;
    case (state_d)
      StGreenBase: load_val = base_time;
      StGreenExt:  load_val = ext_time;
      StYellow:    load_val = yel_time;
      StAllRed:    load_val = clear_time;
      StWalk:      load_val = walk_time;
      default:     load_val = base_time;
    endcase
  end

  assign in_green    = (state_q == StGreenBase) || (state_q == StGreenExt);
  assign enter_walk  = (state_d == StWalk) && (state_q != StWalk);
  assign enter_green = !restart && expired && (state_d == StGreenBase);

  // Demand and walk latches.
  always_comb begin
    demand_d = demand_q;
    for (int unsigned q = 0; q < NUM_PHASES; q++) begin
      if (sensor_sync_in[q] && !(in_green && (phase_q == PhW'(q)))) demand_d[q] = 1'b1;
      // Clear applied after set so that clear wins on a collision.
      if (enter_green && (phase_d == PhW'(q))) demand_d[q] = 1'b0;
    end
    if (prg_sync_in) demand_d = '0;
    // Set after clear: a request on the entry cycle is kept for the next round.
    walk_latch_d = (walk_latch_q & ~enter_walk) | walk_req;
  end

  // Lamps follow the next state so they change on the same edge as the state.
  always_comb begin
    red_d    = '0;
    yellow_d = '0;
    green_d  = '0;
    lamp     = 3'b100;
    for (int unsigned q = 0; q < NUM_PHASES; q++) begin
      lamp        = lamp_decode(state_d, 3'(phase_d), 3'(q));
      red_d[q]    = lamp[2];
      yellow_d[q] = lamp[1];
      green_d[q]  = lamp[0];
    end
    walk_d = (state_d == StWalk);
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q      <= StGreenBase;
      phase_q      <= '0;
      demand_q     <= '0;
      walk_latch_q <= 1'b0;
      walk_ack_q   <= 1'b0;
      walk_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      demand_q     <= demand_d;
      walk_latch_q <= walk_latch_d;
      walk_ack_q   <= enter_walk;
      walk_q       <= walk_d;
    end
    // During reset these decode to green[0] with red elsewhere.
    red_q    <= red_d;
    yellow_q <= yellow_d;
    green_q  <= green_d;
  end

  assign red        = red_q;
  assign yellow     = yellow_q;
  assign green      = green_q;
  assign walk       = walk_q;
  assign walk_ack   = walk_ack_q;
  assign phase_idx  = phase_q;
  assign busy_state = state_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer.
// Three instances share stimulus: d0 (2 phases, no skipping), d1 (2 phases, skipping),
// d4 (4 phases, skipping). Each section resets and checks the instance it targets.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       sys_reset, tick, prg_sync_in, walk_req;
  logic [1:0] sens2;
  logic [3:0] sens4;
  logic [7:0] base_time, ext_time, yel_time, clear_time, walk_time;

  logic [1:0] r0, y0, g0, r1, y1, g1;
  logic [3:0] r4, y4, g4;
  logic       w0, wa0, w1, wa1, w4, wa4;
  logic       pi0, pi1;
  logic [1:0] pi4;
  logic [2:0] bs0, bs1, bs4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.NUM_PHASES(2), .TIMER_W(8), .WALK_PHASE(0), .SKIP_EMPTY(0)) d0 (
    .clk(clk), .sys_reset(sys_reset), .tick(tick), .prg_sync_in(prg_sync_in),
    .sensor_sync_in(sens2), .walk_req(walk_req), .base_time(base_time), .ext_time(ext_time),
    .yel_time(yel_time), .clear_time(clear_time), .walk_time(walk_time),
    .red(r0), .yellow(y0), .green(g0), .walk(w0), .walk_ack(wa0), .phase_idx(pi0),
    .busy_state(bs0)
  );

  phase_sequencer #(.NUM_PHASES(2), .TIMER_W(8), .WALK_PHASE(0), .SKIP_EMPTY(1)) d1 (
    .clk(clk), .sys_reset(sys_reset), .tick(tick), .prg_sync_in(prg_sync_in),
    .sensor_sync_in(sens2), .walk_req(walk_req), .base_time(base_time), .ext_time(ext_time),
    .yel_time(yel_time), .clear_time(clear_time), .walk_time(walk_time),
    .red(r1), .yellow(y1), .green(g1), .walk(w1), .walk_ack(wa1), .phase_idx(pi1),
    .busy_state(bs1)
  );

  phase_sequencer #(.NUM_PHASES(4), .TIMER_W(8), .WALK_PHASE(0), .SKIP_EMPTY(1)) d4 (
    .clk(clk), .sys_reset(sys_reset), .tick(tick), .prg_sync_in(prg_sync_in),
    .sensor_sync_in(sens4), .walk_req(walk_req), .base_time(base_time), .ext_time(ext_time),
    .yel_time(yel_time), .clear_time(clear_time), .walk_time(walk_time),
    .red(r4), .yellow(y4), .green(g4), .walk(w4), .walk_ack(wa4), .phase_idx(pi4),
    .busy_state(bs4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_reset   = 1'b1;
    tick        = 1'b1;
    prg_sync_in = 1'b0;
    walk_req    = 1'b0;
    sens2       = 2'b00;
    sens4       = 4'b0000;
    base_time   = 8'd3;
    ext_time    = 8'd4;
    yel_time    = 8'd2;
    clear_time  = 8'd1;
    walk_time   = 8'd5;
    step(2);

    // Reset state.
    check("rst_green",  32'(g0), 32'h1);
    check("rst_red",    32'(r0), 32'h2);
    check("rst_yellow", 32'(y0), 32'h0);
    check("rst_walk",   32'(w0), 32'h0);
    check("rst_ack",    32'(wa0), 32'h0);
    check("rst_phase",  32'(pi0), 32'h0);
    check("rst_state",  32'(bs0), 32'h0);
    check("rst_cnt",    32'(d0.u_timer.cnt_q), 32'd3);

    // Basic cycle: green 3, yellow 2, all-red 1.
    sys_reset = 1'b0;
    step(2);
    check("gb_hold", 32'(g0), 32'h1);
    step(1);
    check("y_entry_yel", 32'(y0), 32'h1);
    check("y_entry_red", 32'(r0), 32'h2);
    check("y_entry_st",  32'(bs0), 32'd2);
    step(1);
    check("y_hold", 32'(y0), 32'h1);
    step(1);
    check("ar_red", 32'(r0), 32'h3);
    check("ar_st",  32'(bs0), 32'd3);
    step(1);
    check("noskip_green", 32'(g0), 32'h2);
    check("noskip_phase", 32'(pi0), 32'h1);
    check("noskip_red",   32'(r0), 32'h1);
    check("skip_green",   32'(g1), 32'h1);
    check("skip_phase",   32'(pi1), 32'h0);

    // Extension on d1: sensor high at the expiring edge of GREEN_BASE.
    sens2 = 2'b01;
    step(3);
    check("ext_entry_st", 32'(bs1), 32'd1);
    check("ext_green",    32'(g1), 32'h1);
    sens2 = 2'b00;
    step(3);
    check("ext_hold", 32'(bs1), 32'd1);
    step(1);
    check("ext_to_y_st",  32'(bs1), 32'd2);
    check("ext_to_y_yel", 32'(y1), 32'h1);

    // Walk on d1.
    sys_reset = 1'b1;
    step(1);
    sys_reset = 1'b0;
    walk_req  = 1'b1;
    step(1);
    walk_req  = 1'b0;
    step(2);
    check("walk_y_st", 32'(bs1), 32'd2);
    step(2);
    check("walk_ar_st", 32'(bs1), 32'd3);
    walk_req = 1'b1;  // lands on the WALK-entry cycle
    step(1);
    walk_req = 1'b0;
    check("walk_entry_walk", 32'(w1), 32'h1);
    check("walk_entry_ack",  32'(wa1), 32'h1);
    check("walk_entry_st",   32'(bs1), 32'd4);
    check("walk_entry_red",  32'(r1), 32'h3);
    step(1);
    check("walk_ack_drop", 32'(wa1), 32'h0);
    check("walk_hold1",    32'(w1), 32'h1);
    step(3);
    check("walk_hold4", 32'(w1), 32'h1);
    step(1);
    check("walk_end_walk",  32'(w1), 32'h0);
    check("walk_end_green", 32'(g1), 32'h1);
    check("walk_end_st",    32'(bs1), 32'd0);
    step(6);
    check("walk2_walk", 32'(w1), 32'h1);
    check("walk2_ack",  32'(wa1), 32'h1);

    // Four phases with demand only on phase 2.
    sys_reset = 1'b1;
    step(1);
    sys_reset = 1'b0;
    sens4     = 4'b0100;
    step(1);
    sens4     = 4'b0000;
    step(2);
    check("p4_y0_st", 32'(bs4), 32'd2);
    step(2);
    check("p4_ar0_st", 32'(bs4), 32'd3);
    step(1);
    check("p4_phase2",  32'(pi4), 32'd2);
    check("p4_green2",  32'(g4), 32'h4);
    check("p4_red2",    32'(r4), 32'hB);
    step(6);
    check("p4_back0_phase", 32'(pi4), 32'd0);
    check("p4_back0_green", 32'(g4), 32'h1);
    step(3);
    check("p4_round2_y", 32'(bs4), 32'd2);
    step(3);
    check("p4_dem_clr_phase", 32'(pi4), 32'd0);
    check("p4_dem_clr_st",    32'(bs4), 32'd0);

    // Zero yellow interval lasts one tick.
    sys_reset = 1'b1;
    yel_time  = 8'd0;
    step(1);
    sys_reset = 1'b0;
    step(3);
    check("y0_entry_st", 32'(bs1), 32'd2);
    step(1);
    check("y0_to_ar_st", 32'(bs1), 32'd3);

    // Reprogram mid-YELLOW.
    yel_time  = 8'd2;
    sys_reset = 1'b1;
    step(1);
    sys_reset = 1'b0;
    step(4);
    check("prg_pre_st", 32'(bs1), 32'd2);
    base_time   = 8'd5;
    prg_sync_in = 1'b1;
    step(1);
    prg_sync_in = 1'b0;
    check("prg_green",  32'(g1), 32'h1);
    check("prg_yellow", 32'(y1), 32'h0);
    check("prg_st",     32'(bs1), 32'd0);
    check("prg_phase",  32'(pi1), 32'd0);
    check("prg_cnt",    32'(d1.u_timer.cnt_q), 32'd5);
    base_time = 8'd3;

    // Tick held low mid-GREEN_BASE.
    sys_reset = 1'b1;
    step(1);
    sys_reset = 1'b0;
    step(1);
    tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("frz_green", 32'(g1), 32'h1);
      check("frz_red",   32'(r1), 32'h2);
      check("frz_cnt",   32'(d1.u_timer.cnt_q), 32'd2);
    end
    tick = 1'b1;
    step(1);
    check("frz_resume_st", 32'(bs1), 32'd0);
    step(1);
    check("frz_to_y_st", 32'(bs1), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
